// File: rtl/uart_bus_master.sv
// uart_bus_master: register-bus initiator for the UART core. Runs one
// chip-select cycle per accepted command with programmable setup, strobe
// and hold phases, returns read data on a response handshake, and turns
// the core's asynchronous interrupt level into a one-cycle rising-edge pulse.
module uart_bus_master #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_rnw_i,
   input  logic [3:0] cmd_addr_i,
   input  logic [7:0] cmd_wdata_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_rdata_o,
   output logic       busy_o,
   output logic [3:0] AddrBus_o,
   output logic       n_ChipSelect_o,
   output logic       n_rd_o,
   output logic       n_we_o,
   output logic [7:0] DataBus_o,
   input  logic [7:0] DataBus_i,
   input  logic       p_IrqSig_i,
   output logic       p_IrqPulse_o
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;

   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      RESP   = 3'd4
   } busState_e;

   busState_e          state;
   logic [CNT_W-1:0]   phaseCnt;
   logic               isRead;
   logic               cmdReady;
   logic               rspValid;
   logic [DATA_W-1:0]  rspRdata;
   logic               busy;
   logic [ADDR_W-1:0]  addrBus;
   logic [DATA_W-1:0]  dataBus;
   logic               nCs;
   logic               nRd;
   logic               nWe;
   logic               irqSync1;
   logic               irqSync2;
   logic               irqSync2D;
   logic               irqPulse;

   // Bus sequencer: phase counter counts down from length-1 and advances at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         phaseCnt <= '0;
         isRead   <= 1'b0;
         cmdReady <= 1'b0;
         rspValid <= 1'b0;
         rspRdata <= '0;
         busy     <= 1'b0;
         addrBus  <= '0;
         dataBus  <= '0;
         nCs      <= 1'b1;
         nRd      <= 1'b1;
         nWe      <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               cmdReady <= 1'b1;
               busy     <= 1'b0;
               if (cmd_valid_i && cmdReady) begin
                  state    <= SETUP;
                  phaseCnt <= SETUP_LOAD;
                  isRead   <= cmd_rnw_i;
                  cmdReady <= 1'b0;
                  busy     <= 1'b1;
                  nCs      <= 1'b0;
                  addrBus  <= cmd_addr_i;
                  dataBus  <= cmd_rnw_i ? '0 : cmd_wdata_i;
               end
            end
            SETUP: begin
               if (phaseCnt == '0) begin
                  state    <= STROBE;
                  phaseCnt <= STROBE_LOAD;
                  nRd      <= ~isRead;
                  nWe      <= isRead;
               end else begin
                  phaseCnt <= phaseCnt - CNT_W'(1);
               end
            end
            STROBE: begin
               if (phaseCnt == '0) begin
                  state    <= HOLD;
                  phaseCnt <= HOLD_LOAD;
                  nRd      <= 1'b1;
                  nWe      <= 1'b1;
                  if (isRead) begin
                     rspRdata <= DataBus_i;
                  end
               end else begin
                  phaseCnt <= phaseCnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (phaseCnt == '0) begin
                  nCs     <= 1'b1;
                  addrBus <= '0;
                  dataBus <= '0;
                  if (isRead) begin
                     state    <= RESP;
                     rspValid <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     cmdReady <= 1'b1;
                  end
               end else begin
                  phaseCnt <= phaseCnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state    <= IDLE;
                  rspValid <= 1'b0;
                  busy     <= 1'b0;
                  cmdReady <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               cmdReady <= 1'b0;
               rspValid <= 1'b0;
               busy     <= 1'b0;
               nCs      <= 1'b1;
               nRd      <= 1'b1;
               nWe      <= 1'b1;
               addrBus  <= '0;
               dataBus  <= '0;
            end
         endcase
      end
   end

   // Interrupt path: two-flop synchroniser, then a registered rising-edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irqSync1  <= 1'b0;
         irqSync2  <= 1'b0;
         irqSync2D <= 1'b0;
         irqPulse  <= 1'b0;
      end else begin
         irqSync1  <= p_IrqSig_i;
         irqSync2  <= irqSync1;
         irqSync2D <= irqSync2;
         irqPulse  <= irqSync2 & ~irqSync2D;
      end
   end

   assign cmd_ready_o    = cmdReady;
   assign rsp_valid_o    = rspValid;
   assign rsp_rdata_o    = rspRdata;
   assign busy_o         = busy;
   assign AddrBus_o      = addrBus;
   assign DataBus_o      = dataBus;
   assign n_ChipSelect_o = nCs;
   assign n_rd_o         = nRd;
   assign n_we_o         = nWe;
   assign p_IrqPulse_o   = irqPulse;

endmodule
